// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM port arbiter: channel-ID width helper,
// read-latency bounds and the grant-statistics counter width.
package ram_arb_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int STAT_W     = 16;

  function automatic int CH_ID_W(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past the last granted channel and the
// pointer moves only when the grant is taken (advance).
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_CH-1:0]             req,
  output logic [NUM_CH-1:0]             grant,
  output logic [CH_ID_W(NUM_CH)-1:0]    grant_id,
  input  logic                          advance
);

  localparam int IDW = CH_ID_W(NUM_CH);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = IDW'((32'(ptr_q) + i) % NUM_CH);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_id == IDW'(NUM_CH - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_port_arb.sv
// Multi-channel single-port RAM arbiter with read-tag pipeline and response
// routing. Optional per-channel grant counters with RAM_ARB_STATS_EN.
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_write,
  input  logic [NUM_CH*ADDR_W-1:0]   req_address,
  input  logic [NUM_CH*DATA_W-1:0]   req_writedata,
  output logic [NUM_CH-1:0]          rsp_valid,
  output logic [DATA_W-1:0]          rsp_readdata,
  output logic [ADDR_W-1:0]          ram_address,
  output logic                       ram_chipselect,
  output logic                       ram_clken,
  output logic                       ram_write,
  output logic [DATA_W-1:0]          ram_writedata,
  input  logic [DATA_W-1:0]          ram_readdata
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0]   stat_grant_cnt
`endif
);

  localparam int IDW = CH_ID_W(NUM_CH);

  // Assert asynchronously, release two clk_clk edges after reset_reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_sync_q <= '0;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [NUM_CH-1:0] req_gated;
  logic [NUM_CH-1:0] grant;
  logic [IDW-1:0]    grant_id;
  logic              accept;

  assign req_gated = req_valid & {NUM_CH{rst_n}};
  assign req_ready = grant;
  assign accept    = |grant;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk_i    (clk_clk),
    .rst_n_i  (rst_n),
    .req      (req_gated),
    .grant    (grant),
    .grant_id (grant_id),
    .advance  (accept)
  );

  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  cs_q, cs_d;
  logic                  wr_q, wr_d;
  logic [IDW-1:0]        tag_q, tag_d;
  logic [RD_LAT-1:0]     pvld_q, pvld_d;
  logic [RD_LAT*IDW-1:0] pid_q, pid_d;

  // Tag rides alongside the RAM strobe, then shifts RD_LAT stages to meet the data.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = accept;
    wr_d    = 1'b0;
    tag_d   = accept ? grant_id : tag_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        addr_d  = req_address[c*ADDR_W +: ADDR_W];
        wdata_d = req_writedata[c*DATA_W +: DATA_W];
        wr_d    = req_write[c];
      end
    end
    pvld_d = RD_LAT'({pvld_q, cs_q & ~wr_q});
    pid_d  = (RD_LAT*IDW)'({pid_q, tag_q});
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      tag_q   <= '0;
      pvld_q  <= '0;
      pid_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      tag_q   <= tag_d;
      pvld_q  <= pvld_d;
      pid_q   <= pid_d;
    end
  end

  logic           rsp_hit;
  logic [IDW-1:0] rsp_id;

  assign rsp_hit        = pvld_q[RD_LAT-1];
  assign rsp_id         = pid_q[RD_LAT*IDW-1 -: IDW];
  assign rsp_valid      = rsp_hit ? (NUM_CH'(1) << rsp_id) : '0;
  assign rsp_readdata   = rsp_hit ? ram_readdata : '0;
  assign ram_address    = addr_q;
  assign ram_writedata  = wdata_q;
  assign ram_chipselect = cs_q;
  assign ram_write      = wr_q;
  assign ram_clken      = cs_q | (|pvld_q);

`ifdef RAM_ARB_STATS_EN
  logic [NUM_CH*STAT_W-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c] && (stat_q[c*STAT_W +: STAT_W] != '1)) begin
        stat_d[c*STAT_W +: STAT_W] = stat_q[c*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_grant_cnt = stat_q;
`endif

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb (4 channels, RD_LAT=2) with a small RAM model.
module tb_ram_port_arb;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        req_valid, req_ready, req_write, rsp_valid;
  logic [NUM_CH*ADDR_W-1:0] req_address;
  logic [NUM_CH*DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]        rsp_readdata, ram_writedata, ram_readdata;
  logic [ADDR_W-1:0]        ram_address;
  logic                     ram_chipselect, ram_clken, ram_write;
`ifdef RAM_ARB_STATS_EN
  logic [NUM_CH*16-1:0]     stat_grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_port_arb #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_writedata  (req_writedata),
    .rsp_valid      (rsp_valid),
    .rsp_readdata   (rsp_readdata),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_clken      (ram_clken),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_readdata   (ram_readdata)
`ifdef RAM_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  // Background RAM contents, distinct for 0x1xx and 0x3xx rows.
  function automatic logic [7:0] bg(input logic [12:0] a);
    return a[7:0] ^ {a[11:8], 4'h0};
  endfunction

  logic [7:0] mem [0:8191];
  logic [7:0] rd_pipe;

  initial for (int a = 0; a < 8192; a++) mem[a] = bg(13'(a));

  always @(posedge clk) begin
    if (ram_chipselect && ram_write) mem[ram_address] <= ram_writedata;
    rd_pipe      <= mem[ram_address];
    ram_readdata <= rd_pipe;
  end

  logic [39:0] outs;
  assign outs = {req_ready, rsp_valid, rsp_readdata, ram_address, ram_chipselect,
                 ram_clken, ram_write, ram_writedata};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int j;
    int ch;
    req_valid = 4'hF;
    req_write = '0;
    req_address = '0;
    req_writedata = '0;

    // Reset held with requests pending: everything must stay 0
    repeat (3) begin
      @(negedge clk);
      check("rst_outs", 64'(outs), 64'd0);
    end
    step();
    req_valid = '0;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_outs", 64'(outs), 64'd0);
    end
    step();

    // All four channels write continuously
    for (int c = 0; c < NUM_CH; c++) begin
      req_address[c*ADDR_W +: ADDR_W]   = 13'(16 + c);
      req_writedata[c*DATA_W +: DATA_W] = 8'(192 + c);
    end
    req_write = 4'hF;
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        check("rr_addr", 64'(ram_address), 64'(16 + (k - 1) % 4));
        check("rr_cs_wr", 64'({ram_chipselect, ram_write}), 64'(2'b11));
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_tail_ready", 64'(req_ready), 64'd0);
    check("rr_tail", 64'({ram_chipselect, ram_address, ram_writedata}), 64'({1'b1, 13'h13, 8'hC3}));
    step();
    @(negedge clk);
    check("hold_after_idle", 64'({ram_chipselect, ram_write, ram_clken, ram_address, ram_writedata}),
          64'({3'b000, 13'h13, 8'hC3}));
    step();

    // Channel 2: write 0xA5 to 0x1FFF, then read it back
    req_address[2*ADDR_W +: ADDR_W]   = 13'h1FFF;
    req_writedata[2*DATA_W +: DATA_W] = 8'hA5;
    req_write = 4'b0100;
    req_valid = 4'b0100;
    @(negedge clk);
    check("wr_grant", 64'(req_ready), 64'(4'b0100));
    step();
    req_write = '0;
    @(negedge clk);
    check("rd_grant_single", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    @(negedge clk);
    check("rd_strobe", 64'({ram_chipselect, ram_write, ram_address, rsp_valid}),
          64'({2'b10, 13'h1FFF, 4'b0000}));
    step();
    @(negedge clk);
    check("rd_wait", 64'({rsp_valid, ram_clken}), 64'({4'b0000, 1'b1}));
    step();
    @(negedge clk);
    check("rd_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("rd_rsp_data", 64'(rsp_readdata), 64'h0A5);
    step();
    @(negedge clk);
    check("rd_done", 64'({rsp_valid, ram_clken}), 64'd0);
    step();

    // Channels 1 and 3 interleave 8 back-to-back reads
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        req_valid = 4'b1010;
        req_address[1*ADDR_W +: ADDR_W] = 13'(256 + c / 2);
        req_address[3*ADDR_W +: ADDR_W] = 13'(768 + (c + 1) / 2);
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (c < 8) check("b2b_grant", 64'(req_ready), (c % 2 == 0) ? 64'h8 : 64'h2);
      if (c >= 1 && c <= 8) check("b2b_cs", 64'(ram_chipselect), 64'd1);
      if (c >= 3 && c <= 10) begin
        j  = c - 3;
        ch = (j % 2 == 0) ? 3 : 1;
        check("b2b_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << ch));
        check("b2b_rsp_data", 64'(rsp_readdata),
              64'(bg(13'((ch == 3 ? 768 : 256) + j / 2))));
      end else begin
        check("b2b_rsp_idle", 64'(rsp_valid), 64'd0);
      end
      step();
    end

    // Reset one cycle after a read is accepted
    req_address[0 +: ADDR_W] = 13'h040;
    req_valid = 4'b0001;
    @(negedge clk);
    check("pre_rst_grant", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", 64'(outs), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'({rsp_valid, ram_clken}), 64'd0);
    end
    step();
    req_write = 4'hF;
    req_valid = 4'hF;
    @(negedge clk);
    check("ptr_restart0", 64'(req_ready), 64'(4'b0001));
    step();
    @(negedge clk);
    check("ptr_restart1", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;

`ifdef RAM_ARB_STATS_EN
    req_valid = 4'b0001;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("stat_sat_ch0", 64'(stat_grant_cnt[15:0]), 64'hFFFF);
    check("stat_ch1", 64'(stat_grant_cnt[31:16]), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arb.md
RAM_PORT_ARB -- requirements
Module: ram_port_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 13, RAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-004 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles (1..3).
REQ-005 SHALL have one clock and one reset: the clock is clk_clk, and the reset is reset_reset_n, asynchronous and active-low.
REQ-006 clk_clk  in  1  block clock, rising edge.
REQ-007 reset_reset_n  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  NUM_CH  per-channel request valid.
REQ-009 req_ready  out  NUM_CH  per-channel request accepted this cycle.
REQ-010 req_write  in  NUM_CH  per-channel: 1=write, 0=read.
REQ-011 req_address  in  NUM_CH*ADDR_W  flattened per-channel address, channel 0 in the LSBs.
REQ-012 req_writedata  in  NUM_CH*DATA_W  flattened per-channel write data.
REQ-013 rsp_valid  out  NUM_CH  one-cycle read-data strobe per channel.
REQ-014 rsp_readdata  out  DATA_W  read data, shared by all channels and qualified by rsp_valid.
REQ-015 ram_address  out  ADDR_W  RAM address.
REQ-016 ram_chipselect  out  1  RAM access strobe.
REQ-017 ram_clken  out  1  RAM clock enable.
REQ-018 ram_write  out  1  RAM write strobe.
REQ-019 ram_writedata  out  DATA_W  RAM write data.
REQ-020 ram_readdata  in  DATA_W  RAM read data, valid RD_LAT cycles after a read strobe.

Function
REQ-021 SHALL grant at most one channel per cycle, using round-robin priority.
REQ-022 Priority SHALL start at (last granted channel + 1) mod NUM_CH; after reset it SHALL start at channel 0.
REQ-023 A channel's request SHALL be accepted in the cycle where its req_valid and req_ready are both 1.
REQ-024 req_ready SHALL be combinational and one-hot-or-zero.
REQ-025 An accepted request SHALL be registered onto the ram_* outputs one cycle later, with ram_chipselect=1 for exactly one cycle per request.
REQ-026 When no request is accepted, the next cycle SHALL drive ram_chipselect=0 and ram_write=0, and SHALL hold ram_address and ram_writedata.
REQ-027 A read SHALL push the granted channel ID into an RD_LAT-deep tag pipeline.
REQ-028 RD_LAT cycles after ram_chipselect, the block SHALL pulse rsp_valid[ID] and drive rsp_readdata=ram_readdata in the same cycle (combinational pass-through).
REQ-029 Back-to-back reads from any channels SHALL be accepted every cycle, with responses returned in issue order; no bubbles.
REQ-030 Writes SHALL produce no response.
REQ-031 ram_clken SHALL be 1 while ram_chipselect=1 or the tag pipeline holds any read; otherwise it SHALL be 0.
REQ-032 A requester deasserting req_valid without acceptance SHALL be legal; the arbiter pointer SHALL advance only on acceptance.
REQ-033 With a single active channel, that channel SHALL be granted every cycle.

Reset
REQ-034 While reset_reset_n=0, all outputs SHALL be 0, the tag pipeline SHALL be empty and the pointer SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard in-flight reads, and no rsp_valid SHALL appear after reset release.
REQ-036 Reset deassertion SHALL be synchronised to clk_clk by a 2-flop synchroniser inside the block.

Configuration
REQ-037 With macro RAM_ARB_STATS_EN defined, the block SHALL add output stat_grant_cnt, NUM_CH*16 bits: a per-channel saturating grant counter, cleared by reset, that holds at 16'hFFFF.
REQ-038 With RAM_ARB_STATS_EN undefined, the stat_grant_cnt port and its logic SHALL be absent.

Structure
REQ-039 Package ram_arb_pkg SHALL hold the channel-ID width function clog2-based CH_ID_W(NUM_CH), the RD_LAT bounds and the stat counter width constant (16).
REQ-040 The round-robin grant logic SHALL be the sub-module rr_arbiter, with ports req, grant and advance, parametrised by NUM_CH.

Verification
REQ-041 Reset then idle: all outputs 0 and ram_clken=0 for 10 cycles.
REQ-042 Channels 0..3 all request writes to addresses 0x10..0x13 continuously: grants SHALL be 0,1,2,3,0,... and ram_address SHALL follow one cycle later.
REQ-043 Channel 2 writes 0xA5 to 0x1FFF, then reads 0x1FFF, with RD_LAT=2: rsp_valid[2]=1 and rsp_readdata=0xA5 exactly 3 cycles after read acceptance.
REQ-044 Channels 1 and 3 interleave 8 back-to-back reads: every cycle shall carry ram_chipselect=1, and the 8 responses shall return in order on the correct rsp_valid bits.
REQ-045 Reset is pulsed 1 cycle after a read is accepted: no rsp_valid shall follow, and the pointer shall restart at channel 0.
REQ-046 With RAM_ARB_STATS_EN defined, 70000 grants to channel 0 shall leave stat_grant_cnt[15:0]=16'hFFFF.
